// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the three-register select-line bank and its
// write arbiter.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] ADDR_IDLE = 2'b00;
    localparam logic [1:0] ADDR_Q0   = 2'b01;
    localparam logic [1:0] ADDR_Q1   = 2'b10;
    localparam logic [1:0] ADDR_Q2   = 2'b11;

    // Index of a one-hot requester vector; zero vector maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters; search starts just
// after the most recently served index and wraps.
module rr_pick3
    import reg_bank_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    always_comb begin
        int start;
        int idx;
        // NOTE: every output gets a default before any branch so the block
        // stays purely combinational instead of inferring a latch.
        pick  = '0;
        valid = 1'b0;
        start = 0;
        idx   = 0;
        case (last)
            2'd0:    start = 1;
            2'd1:    start = 2;
            default: start = 0;
        endcase
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter in front of the three-register bank.
// Optional burst lock enabled by defining REGARB_LOCK_EN.
module reg_bank_wr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [1:0]          wr_addr0,
    input  logic [1:0]          wr_addr1,
    input  logic [1:0]          wr_addr2,
    input  logic [DATA_W-1:0]   wr_data0,
    input  logic [DATA_W-1:0]   wr_data1,
    input  logic [DATA_W-1:0]   wr_data2,
`ifdef REGARB_LOCK_EN
    input  logic [NUM_REQ-1:0]  lock,
`endif
    output logic [NUM_REQ-1:0]  gnt,
    output logic [NUM_REQ-1:0]  done,
    output logic [DATA_W-1:0]   bank_d,
    output logic [1:0]          bank_addr,
    output logic                busy
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST must lie in 1..15");
    end

    state_t              state, next_state;
    logic [1:0]          last, next_last;
    logic [NUM_REQ-1:0]  next_gnt, next_done;
    logic [DATA_W-1:0]   next_d;
    logic [1:0]          next_addr;

    logic [NUM_REQ-1:0]  pick;
    logic                pick_valid;
    logic [1:0]          sel_idx;
    logic [1:0]          sel_addr;
    logic [DATA_W-1:0]   sel_data;

`ifdef REGARB_LOCK_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    logic [3:0]          burst_cnt, next_burst;
`endif

    rr_pick3 u_pick (
        .req   (req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    // In IDLE the fresh winner selects the source; in DONE (burst reload) the
    // current grant holder does.
    always_comb begin
        sel_idx = (state == IDLE) ? onehot_to_idx(pick) : onehot_to_idx(gnt);
        case (sel_idx)
            2'd1: begin
                sel_addr = wr_addr1;
                sel_data = wr_data1;
            end
            2'd2: begin
                sel_addr = wr_addr2;
                sel_data = wr_data2;
            end
            default: begin
                sel_addr = wr_addr0;
                sel_data = wr_data0;
            end
        endcase
    end

    always_comb begin
        next_state = state;
        next_last  = last;
        next_gnt   = gnt;
        next_done  = done;
        next_addr  = bank_addr;
        next_d     = bank_d;
`ifdef REGARB_LOCK_EN
        next_burst = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = WRITE;
                    next_gnt   = pick;
                    next_addr  = sel_addr;
                    next_d     = sel_data;
                end
            end
            WRITE: begin
                next_state = DONE;
                next_done  = gnt;
                next_addr  = ADDR_IDLE;
                next_d     = '0;
            end
            DONE: begin
                next_state = IDLE;
                next_gnt   = '0;
                next_done  = '0;
                next_last  = sel_idx;
`ifdef REGARB_LOCK_EN
                next_burst = '0;
                // A locked holder that still requests re-enters WRITE without
                // giving up its grant or advancing the rotation.
                if (lock[sel_idx] && req[sel_idx] && (burst_cnt < BURST_LAST)) begin
                    next_state = WRITE;
                    next_gnt   = gnt;
                    next_last  = last;
                    next_addr  = sel_addr;
                    next_d     = sel_data;
                    next_burst = burst_cnt + 4'd1;
                end
`endif
            end
            default: begin
                next_state = IDLE;
                next_gnt   = '0;
                next_done  = '0;
                next_addr  = ADDR_IDLE;
                next_d     = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd2;
            gnt       <= '0;
            done      <= '0;
            bank_addr <= ADDR_IDLE;
            bank_d    <= '0;
`ifdef REGARB_LOCK_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= next_state;
            last      <= next_last;
            gnt       <= next_gnt;
            done      <= next_done;
            bank_addr <= next_addr;
            bank_d    <= next_d;
`ifdef REGARB_LOCK_EN
            burst_cnt <= next_burst;
`endif
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Self-checking bench for reg_bank_wr_arbiter: vector table plus hand-written
// reset and burst sequences, with a behavioural model of the register bank.
module tb_reg_bank_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [1:0] wr_addr0, wr_addr1, wr_addr2;
    logic [7:0] wr_data0, wr_data1, wr_data2;
    logic [2:0] lock;
    logic [2:0] gnt, done;
    logic [7:0] bank_d;
    logic [1:0] bank_addr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_wr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr_addr0  (wr_addr0),
        .wr_addr1  (wr_addr1),
        .wr_addr2  (wr_addr2),
        .wr_data0  (wr_data0),
        .wr_data1  (wr_data1),
        .wr_data2  (wr_data2),
`ifdef REGARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .done      (done),
        .bank_d    (bank_d),
        .bank_addr (bank_addr),
        .busy      (busy)
    );

    // Register bank: writes q[addr-1] on the rising edge when addr != 00;
    // deliberately not reset so an arbiter reset cannot disturb it.
    logic [7:0] q [3];
    initial begin
        q[0] = 8'h00;
        q[1] = 8'h00;
        q[2] = 8'h00;
    end
    always @(posedge clk) begin
        if (bank_addr != 2'b00) q[bank_addr - 2'd1] <= bank_d;
    end

    typedef struct {
        logic [2:0] req;
        logic [1:0] a0, a1, a2;
        logic [7:0] d0, d1, d2;
        logic [2:0] gnt, done;
        logic [1:0] addr;
        logic [7:0] d;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] r, logic [1:0] a0, logic [1:0] a1, logic [1:0] a2,
                                logic [7:0] d0, logic [7:0] d1, logic [7:0] d2,
                                logic [2:0] g, logic [2:0] dn, logic [1:0] ad,
                                logic [7:0] dd, logic b);
        vec_t v;
        v.req = r;  v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0;  v.d1 = d1; v.d2 = d2;
        v.gnt = g;  v.done = dn; v.addr = ad; v.d = dd; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] g, input logic [2:0] dn,
                              input logic [1:0] ad, input logic [7:0] dd, input logic b);
        check({tag, " gnt"},       32'(gnt),       32'(g));
        check({tag, " done"},      32'(done),      32'(dn));
        check({tag, " bank_addr"}, 32'(bank_addr), 32'(ad));
        check({tag, " bank_d"},    32'(bank_d),    32'(dd));
        check({tag, " busy"},      32'(busy),      32'(b));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Defaults: q0/q1/q2 addresses with distinct data per requester.
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b001, 3'b000, 2'b01, 8'h11, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b001, 3'b001, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b010, 3'b000, 2'b10, 8'h22, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b010, 3'b010, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b100, 3'b000, 2'b11, 8'h33, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b100, 3'b100, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b001, 3'b000, 2'b01, 8'h11, 1'b1));
        vecs.push_back(mk(3'b111, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b001, 3'b001, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        // Single write by requester 1, data changed after grant.
        vecs.push_back(mk(3'b010, 2'b01, 2'b10, 2'b11, 8'h11, 8'hAA, 8'h33, 3'b010, 3'b000, 2'b10, 8'hAA, 1'b1));
        vecs.push_back(mk(3'b010, 2'b01, 2'b10, 2'b11, 8'h11, 8'h55, 8'h33, 3'b010, 3'b010, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b11, 8'h11, 8'h55, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        // Address 00 from requester 2, withdrawn during DONE.
        vecs.push_back(mk(3'b100, 2'b01, 2'b10, 2'b00, 8'h11, 8'h55, 8'hFF, 3'b100, 3'b000, 2'b00, 8'hFF, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b00, 8'h11, 8'h55, 8'hFF, 3'b100, 3'b100, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b00, 8'h11, 8'h55, 8'hFF, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));
        // Requester 0 withdraws during WRITE; write still completes.
        vecs.push_back(mk(3'b001, 2'b01, 2'b10, 2'b11, 8'h5A, 8'h55, 8'h33, 3'b001, 3'b000, 2'b01, 8'h5A, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b11, 8'h00, 8'h55, 8'h33, 3'b001, 3'b001, 2'b00, 8'h00, 1'b1));
        vecs.push_back(mk(3'b000, 2'b01, 2'b10, 2'b11, 8'h00, 8'h55, 8'h33, 3'b000, 3'b000, 2'b00, 8'h00, 1'b0));

        req = 3'b111; lock = 3'b000;
        wr_addr0 = 2'b01; wr_addr1 = 2'b10; wr_addr2 = 2'b11;
        wr_data0 = 8'h11; wr_data1 = 8'h22; wr_data2 = 8'h33;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outs("reset", 3'b000, 3'b000, 2'b00, 8'h00, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            wr_addr0 = vecs[i].a0; wr_addr1 = vecs[i].a1; wr_addr2 = vecs[i].a2;
            wr_data0 = vecs[i].d0; wr_data1 = vecs[i].d1; wr_data2 = vecs[i].d2;
            @(posedge clk);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done,
                          vecs[i].addr, vecs[i].d, vecs[i].busy);
        end
        check("bank q0", 32'(q[0]), 32'h5A);
        check("bank q1", 32'(q[1]), 32'hAA);
        check("bank q2", 32'(q[2]), 32'h33);

        // Reset asserted in the WRITE cycle drops the write and its done.
        req = 3'b010; wr_addr1 = 2'b10; wr_data1 = 8'h77;
        @(posedge clk);
        #1 check("midrst write gnt", 32'(gnt), 32'b010);
        rst_n = 1'b0;
        #1 check_outs("midrst", 3'b000, 3'b000, 2'b00, 8'h00, 1'b0);
        req = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 check($sformatf("midrst done c%0d", c), 32'(done), 32'b000);
            if (c == 1) rst_n = 1'b1;
        end
        check("midrst q1 kept", 32'(q[1]), 32'hAA);

        // After reset requester 0 has first priority again.
        req = 3'b111;
        @(posedge clk);
        #1 check("post-reset first gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        repeat (2) @(posedge clk);
        #1 check("post-reset idle", 32'(busy), 32'b0);

`ifdef REGARB_LOCK_EN
        begin
            logic [2:0] exp_gnt [10];
            logic [2:0] exp_done[10];
            exp_gnt  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010};
            exp_done = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000};
            do_reset();
            req = 3'b011; lock = 3'b001;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1 check($sformatf("burst gnt c%0d", c), 32'(gnt), 32'(exp_gnt[c]));
                check($sformatf("burst done c%0d", c), 32'(done), 32'(exp_done[c]));
            end
            req = 3'b000; lock = 3'b000;
            repeat (3) @(posedge clk);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_wr_arbiter.md
# reg_bank_wr_arbiter

Round-robin write arbiter that shares the single write port of the three-register select-line bank between three independent requesters. It latches the winning requester's address and data and drives the bank's `d`/`addr` inputs for exactly one cycle. It then returns a one-cycle completion pulse. It sits directly in front of the register bank; the bank's `q0..q2` outputs are not routed through it.

## Interface
Parameters:
- `DATA_W`, default 8: data width; must match the bank's `d`.
- `MAX_BURST`, default 4: maximum consecutive writes by one locked requester. Used only with `REGARB_LOCK_EN`; legal range 1–15.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  3: per-requester write request, level.
- `wr_addr0`, `wr_addr1`, `wr_addr2`  in  2 each: target select per requester.
- `wr_data0`, `wr_data1`, `wr_data2`  in  `DATA_W` each: write data per requester.
- `lock`  in  3: per-requester burst lock. Present only with `REGARB_LOCK_EN`.
- `gnt`  out  3: one-hot grant, registered.
- `done`  out  3: one-hot completion pulse, registered.
- `bank_d`  out  `DATA_W`: drives the bank's `d`.
- `bank_addr`  out  2: drives the bank's `addr`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- `bank_addr` encoding: 2'b00 = idle, no write. 2'b01, 2'b10 and 2'b11 write `q0`, `q1` and `q2` respectively.
- State machine has three states: IDLE, WRITE, DONE.
- **IDLE**
  - Outputs: `gnt`=0, `done`=0, `bank_addr`=00, `bank_d`=0.
  - If `req`≠0, pick a winner and go to WRITE.
- **Winner selection**
  - Search order starts at requester (`last`+1) mod 3 and wraps around.
  - `last` is the index of the most recently completed requester.
- **IDLE→WRITE edge**
  - Latch the winner's `wr_addr`/`wr_data` into `bank_addr`/`bank_d`.
  - Set `gnt[w]`=1.
- **WRITE**
  - `bank_addr`/`bank_d` are held for exactly one cycle.
  - Next state is DONE unconditionally.
- **DONE**
  - `done[w]`=1 and `gnt[w]` stays 1.
  - `bank_addr`=00 and `bank_d`=0.
  - `last` is set to w.
  - Next state is IDLE.
- **Requester obligations**
  - The requester must drop `req` in the cycle after it sees `done`.
  - If `req[w]` is still high in IDLE, it is treated as a new request.
- **Latching and withdrawal**
  - Address and data are latched at grant, so the requester may change them while `gnt` is high.
  - Deasserting `req` during WRITE or DONE does not abort the write.
- **Address 00:** a requester presenting `wr_addr`=00 is granted and receives `done`; the bank sees no write.
- **Reset:** `rst_n` low asynchronously forces IDLE, all outputs to 0, `last`=2 (so requester 0 has first priority) and the burst count to 0. A write in progress is dropped with no `done`.

## Timing
- **Latency:** `req` sampled at edge E0 → `gnt` and the bank drive valid after E0. The bank captures at E1; `done` is high between E1 and E2.
- **Throughput:** one write per 3 cycles. Three continuously requesting masters are served in the order 0, 1, 2, 0, …
- **Simultaneous requests:** resolved by the rotating order only; there is no fixed priority.
- **New request during DONE:** waits for the IDLE cycle, with no starvation. The worst-case wait is 2 other grants, i.e. 6 cycles plus own latency.

## Configuration
- Macro: `REGARB_LOCK_EN`.
- **Defined**
  - In DONE, if `lock[w]` and `req[w]` are both high and the burst count is below `MAX_BURST`-1, go directly to WRITE.
  - On that transition, latch the new `wr_addr`/`wr_data`, keep `gnt[w]`, increment the burst count, and leave `last` unchanged.
  - Throughput during a burst is one write per 2 cycles.
  - When the burst limit is reached or `lock` drops, follow the normal DONE→IDLE path and clear the burst count.
- **Undefined:** the `lock` port and the burst counter do not exist; behaviour is as in Operation.

## Structure
- **Shared package `reg_bank_pkg`**
  - State enum: IDLE, WRITE, DONE.
  - Address constants: `ADDR_IDLE`=2'b00, `ADDR_Q0`=2'b01, `ADDR_Q1`=2'b10, `ADDR_Q2`=2'b11.
  - `NUM_REQ`=3.
- **Sub-module `rr_pick3`**
  - Combinational.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: one-hot `pick[2:0]`, `valid`.

## Test plan
- **Reset values:** with `rst_n`=0, drive `req`=3'b111 → `gnt`=0, `done`=0, `bank_addr`=00, `busy`=0. After release, the first grant goes to requester 0.
- **Single write:** `req[1]`=1, `wr_addr1`=2'b10, `wr_data1`=8'hAA → one edge later `gnt`=3'b010, `bank_addr`=10, `bank_d`=8'hAA for one cycle. `done`=3'b010 on the next cycle and the bank's `q1`=8'hAA.
- **Round-robin:** hold `req`=3'b111 with distinct data → grant order 0, 1, 2, 0, one grant every 3 cycles, and each `done` matches its grant.
- **Address 00 and withdrawal:** requester 2 with `wr_addr2`=00 and `wr_data2`=8'hFF gets `done`, with no change to `q0..q2`. Requester 0 dropping `req` during WRITE still completes its write.
- **Mid-write reset:** assert `rst_n`=0 in the WRITE cycle → `bank_addr` goes to 00 immediately, no `done` pulse, and `q` values change only if the bank's own reset applies.
- **Burst (`REGARB_LOCK_EN`, `MAX_BURST`=4):** `lock[0]`=`req[0]`=1 with `req[1]`=1 → four writes by requester 0, 2 cycles apart, then requester 1 is granted.
